// File: rtl/vdcm_pkg.sv
// Shared defaults and types for the substream word fetch path.
package vdcm_pkg;

  localparam int NUM_SSM_DEF   = 4;
  localparam int WORD_W_DEF    = 128;
  localparam int BUF_DEPTH_DEF = 8;
  localparam int TOT_W         = 12;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_PREFILL = 2'd1,
    FETCH_RUN     = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ssm_fetch_arb_if.sv
// Upstream beat and per-substream read bus between the fetch arbiter and its neighbours.
interface ssm_fetch_arb_if
  import vdcm_pkg::*;
#(
  parameter int NUM_SSM = NUM_SSM_DEF,
  parameter int WORD_W  = WORD_W_DEF
);
  // Upstream beat moves when in_valid & in_ready at posedge; in_valid may not depend on in_ready.
  // Each rd_gnt[i] is a same-cycle answer to rd_req[i]; rd_data slice i is only meaningful when granted.
  logic                        in_valid;
  logic [NUM_SSM*WORD_W-1:0]   in_data;
  logic                        in_ready;
  logic [NUM_SSM-1:0]          rd_req;
  logic [NUM_SSM-1:0]          rd_gnt;
  logic [NUM_SSM*WORD_W-1:0]   rd_data;

  modport master (
    output in_valid, in_data, rd_req,
    input  in_ready, rd_gnt, rd_data
  );

  modport slave (
    input  in_valid, in_data, rd_req,
    output in_ready, rd_gnt, rd_data
  );

endinterface

// File: rtl/ssm_word_buf.sv
// Circular word buffer: NUM_SSM-word push at tail, indexed reads relative to head, pop of 0..NUM_SSM.
module ssm_word_buf #(
  parameter  int NUM_SSM   = 4,
  parameter  int WORD_W    = 128,
  parameter  int BUF_DEPTH = 8,
  localparam int PTR_W     = $clog2(BUF_DEPTH),
  localparam int OCC_W     = PTR_W + 1,
  localparam int CNT_W     = $clog2(NUM_SSM + 1)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      flush,
  input  logic                      push,
  input  logic [NUM_SSM*WORD_W-1:0] push_data,
  input  logic [CNT_W-1:0]          pop_cnt,
  input  logic [NUM_SSM*PTR_W-1:0]  rd_off,
  output logic [NUM_SSM*WORD_W-1:0] rd_word,
  output logic [OCC_W-1:0]          occ
);

  logic [WORD_W-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;

  // Flush wins over a same-cycle push/pop: restart or session end drops everything.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      head <= head + PTR_W'(pop_cnt);
      if (push) tail <= tail + PTR_W'(NUM_SSM);
      occ <= occ + (push ? OCC_W'(NUM_SSM) : '0) - OCC_W'(pop_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int j = 0; j < NUM_SSM; j++) begin
        mem[tail + PTR_W'(j)] <= push_data[j*WORD_W +: WORD_W];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_SSM; i++) begin
      rd_word[i*WORD_W +: WORD_W] = mem[head + rd_off[i*PTR_W +: PTR_W]];
    end
  end

endmodule

// File: rtl/ssm_fetch_arb.sv
// Hands bitstream words to substream parsers in strict stream order, ssm0 first each cycle.
module ssm_fetch_arb
  import vdcm_pkg::*;
#(
  parameter int NUM_SSM   = NUM_SSM_DEF,
  parameter int WORD_W    = WORD_W_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_dec,
  input  logic [TOT_W-1:0]  total_words,
  ssm_fetch_arb_if.slave    bus,
  output logic [TOT_W-1:0]  words_used,
  output logic              busy,
  output logic              done,
  output fetch_state_e      dbg_state
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = $clog2(NUM_SSM + 1);
  localparam int CMP_W = TOT_W + 1;

  fetch_state_e              state_q, state_d;
  logic [TOT_W-1:0]          tot_q;
  logic [CMP_W-1:0]          fetched_q;
  logic [OCC_W-1:0]          occ;
  logic [CNT_W-1:0]          rank_acc;
  logic [CNT_W-1:0]          pop_cnt;
  logic [NUM_SSM-1:0]        gnt;
  logic [NUM_SSM*PTR_W-1:0]  rd_off;
  logic [NUM_SSM*WORD_W-1:0] rd_word;
  logic [CMP_W-1:0]          used_next;
  logic [TOT_W-1:0]          remaining;
  logic                      push, flush, in_run, space_ok;

  assign busy      = (state_q != FETCH_IDLE);
  assign dbg_state = state_q;
  assign in_run    = (state_q == FETCH_RUN) && !start_dec;
  assign space_ok  = (occ <= OCC_W'(BUF_DEPTH - NUM_SSM));

  assign bus.in_ready = busy && space_ok && (fetched_q < {1'b0, tot_q});
  assign push         = bus.in_valid && bus.in_ready;

  // rank = number of lower-index requesters; a requester whose rank runs past the
  // buffered words or the session end is refused, and so is everyone above it.
  always_comb begin
    rank_acc = '0;
    pop_cnt  = '0;
    gnt      = '0;
    rd_off   = '0;
    for (int i = 0; i < NUM_SSM; i++) begin
      rd_off[i*PTR_W +: PTR_W] = PTR_W'(rank_acc);
      if (in_run && bus.rd_req[i] && (OCC_W'(rank_acc) < occ) &&
          (({1'b0, words_used} + CMP_W'(rank_acc)) < {1'b0, tot_q})) begin
        gnt[i]  = 1'b1;
        pop_cnt = pop_cnt + CNT_W'(1);
      end
      if (bus.rd_req[i]) rank_acc = rank_acc + CNT_W'(1);
    end
  end

  assign bus.rd_gnt = gnt;

  always_comb begin
    bus.rd_data = '0;
    for (int i = 0; i < NUM_SSM; i++) begin
      if (gnt[i]) bus.rd_data[i*WORD_W +: WORD_W] = rd_word[i*WORD_W +: WORD_W];
    end
  end

  assign used_next = {1'b0, words_used} + CMP_W'(pop_cnt);
  assign remaining = tot_q - words_used;

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      FETCH_PREFILL: begin
        if (tot_q == '0) begin
          done    = 1'b1;
          state_d = FETCH_IDLE;
        end else if ((occ >= OCC_W'(NUM_SSM)) || (CMP_W'(occ) >= {1'b0, remaining})) begin
          state_d = FETCH_RUN;
        end
      end
      FETCH_RUN: begin
        if ((pop_cnt != '0) && (used_next == {1'b0, tot_q})) begin
          done    = 1'b1;
          state_d = FETCH_IDLE;
        end
      end
      default: ;
    endcase
    // A restart overrides whatever the session was doing this cycle.
    if (start_dec) begin
      state_d = FETCH_PREFILL;
      done    = 1'b0;
    end
  end

  assign flush = start_dec || done;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= FETCH_IDLE;
      tot_q      <= '0;
      words_used <= '0;
      fetched_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_dec) begin
        tot_q      <= total_words;
        words_used <= '0;
        fetched_q  <= '0;
      end else begin
        words_used <= words_used + TOT_W'(pop_cnt);
        if (push) fetched_q <= fetched_q + CMP_W'(NUM_SSM);
      end
    end
  end

  ssm_word_buf #(
    .NUM_SSM   (NUM_SSM),
    .WORD_W    (WORD_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .push      (push),
    .push_data (bus.in_data),
    .pop_cnt   (pop_cnt),
    .rd_off    (rd_off),
    .rd_word   (rd_word),
    .occ       (occ)
  );

endmodule
